// File: rtl/chebyshev_clenshaw_ctrl.sv
// Clenshaw-recurrence sequencer for Chebyshev series on one shared MAC path.
// Optional sticky overflow output is enabled with the CHEB_OVF_FLAG_EN macro.
`timescale 1ns/1ps

module chebyshev_saturation #(
  parameter int WL                    = 16,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3,
  localparam int O_BITS               = WL - (I_BITS - BOUNDARY_BIT_POSITION)
) (
  input  logic [WL-1:0]     x_i,
  output logic [O_BITS-1:0] y_o
);
  logic [WL-O_BITS:0] hi;
  logic               in_range;

  assign hi       = x_i[WL-1:O_BITS-1];
  assign in_range = (hi == '0) || (hi == '1);

  always_comb begin
    if (in_range)      y_o = x_i[O_BITS-1:0];
    else if (x_i[WL-1]) y_o = {1'b1, {(O_BITS-1){1'b0}}};
    else               y_o = {1'b0, {(O_BITS-1){1'b1}}};
  end
endmodule

module chebyshev_clenshaw_ctrl #(
  parameter int WL                    = 16,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3,
  parameter int MAX_DEG               = 15,
  localparam int ADDR_W               = $clog2(MAX_DEG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WL-1:0]     x_in,
  input  logic [ADDR_W-1:0] degree_in,
  output logic              coeff_rd,
  output logic [ADDR_W-1:0] coeff_addr,
  input  logic [WL-1:0]     coeff_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WL-1:0]     y_out
`ifdef CHEB_OVF_FLAG_EN
  ,
  output logic              ovf
`endif
);
  localparam int F_BITS = WL - I_BITS;
  localparam int O_BITS = WL - (I_BITS - BOUNDARY_BIT_POSITION);
  // Wide enough that 2*xs*b1 - b2 + c never wraps before saturation.
  localparam int ACC_W  = 2 * WL + 2;
  localparam logic [ADDR_W-1:0] MAX_DEG_A = ADDR_W'(MAX_DEG);

  typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       k_q, k_d;
  logic signed [WL-1:0]    xs_q, xs_d;
  logic signed [WL-1:0]    b1_q, b1_d;
  logic signed [WL-1:0]    b2_q, b2_d;
  logic [WL-1:0]           y_q, y_d;
  logic                    rdy_q;

  logic [O_BITS-1:0]       xsat;
  logic [WL-1:0]           xs_ext;
  logic [ADDR_W-1:0]       deg_c;
  logic                    accept;

  logic signed [2*WL-1:0]  xs_w, b1_w, prod;
  logic signed [ACC_W-1:0] term_raw, term_dbl, term, b2_ext, c_ext, sum;
  logic signed [WL-1:0]    t_sat;

  function automatic logic sum_ovf(input logic signed [ACC_W-1:0] s);
    return !((s[ACC_W-1:WL-1] == '0) || (s[ACC_W-1:WL-1] == '1));
  endfunction

  function automatic logic signed [WL-1:0] sat_wl(input logic signed [ACC_W-1:0] s);
    if (!sum_ovf(s)) return s[WL-1:0];
    if (s[ACC_W-1])  return {1'b1, {(WL-1){1'b0}}};
    return {1'b0, {(WL-1){1'b1}}};
  endfunction

  chebyshev_saturation #(
    .WL(WL), .I_BITS(I_BITS), .BOUNDARY_BIT_POSITION(BOUNDARY_BIT_POSITION)
  ) u_sat (
    .x_i (x_in),
    .y_o (xsat)
  );

  assign xs_ext = {{(WL-O_BITS){xsat[O_BITS-1]}}, xsat};
  assign deg_c  = (degree_in > MAX_DEG_A) ? MAX_DEG_A : degree_in;
  assign accept = (state_q == IDLE) && in_valid && rdy_q;

  // Shared MAC: full-width product, doubled except for the final term, floor-realigned.
  assign xs_w     = {{WL{xs_q[WL-1]}}, xs_q};
  assign b1_w     = {{WL{b1_q[WL-1]}}, b1_q};
  assign prod     = xs_w * b1_w;
  assign term_raw = {{(ACC_W-2*WL){prod[2*WL-1]}}, prod};
  assign term_dbl = (k_q != '0) ? (term_raw <<< 1) : term_raw;
  assign term     = term_dbl >>> F_BITS;
  assign b2_ext   = {{(ACC_W-WL){b2_q[WL-1]}}, b2_q};
  assign c_ext    = {{(ACC_W-WL){coeff_data[WL-1]}}, coeff_data};
  assign sum      = term - b2_ext + c_ext;
  assign t_sat    = sat_wl(sum);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xs_d    = xs_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          xs_d    = xs_ext;
          k_d     = deg_c;
          b1_d    = '0;
          b2_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = ACC;
      ACC: begin
        b2_d = b1_q;
        b1_d = t_sat;
        if (k_q == '0) begin
          y_d     = t_sat;
          state_d = DONE;
        end else begin
          k_d     = k_q - ADDR_W'(1);
          state_d = FETCH;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      xs_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      y_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xs_q    <= xs_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      y_q     <= y_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  // k only moves on acceptance or on entry to FETCH, so it doubles as the held address.
  assign in_ready   = rdy_q;
  assign coeff_rd   = (state_q == FETCH);
  assign coeff_addr = k_q;
  assign out_valid  = (state_q == DONE);
  assign y_out      = y_q;

`ifdef CHEB_OVF_FLAG_EN
  logic flag_q, flag_d;
  logic ovf_q, ovf_d;
  logic x_clamp;

  assign x_clamp = (xs_ext != x_in);

  always_comb begin
    flag_d = flag_q;
    ovf_d  = ovf_q;
    if (accept) begin
      flag_d = x_clamp;
      ovf_d  = 1'b0;
    end else if (state_q == ACC) begin
      flag_d = flag_q | sum_ovf(sum);
      if (k_q == '0) ovf_d = flag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
